// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: registered EX operand-forward selects plus load-use stall.
// Define HAZARD_STATS_EN to add saturating stall_count/fwd_count statistics outputs.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      fwd_count
`endif
);

  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_rw;
  logic                  ex_mr;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_rw;
  logic                  bubble;
  logic [1:0]            fwd_a_d;
  logic [1:0]            fwd_b_d;

  // Youngest producer wins; x0 is never a forwarding source.
  function automatic logic [1:0] pick_src(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  e_rw,
    input logic [REG_ADDR_W-1:0] e_rd,
    input logic                  m_rw,
    input logic [REG_ADDR_W-1:0] m_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && e_rw && e_rd != '0 && rs == e_rd)
      sel = 2'b10;
    else if (uses && m_rw && m_rd != '0 && rs == m_rd)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush && ex_mr && ex_rw && ex_rd != '0 &&
        ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)))
      stall = 1'b1;
  end

  assign bubble = flush || stall || !id_valid;

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!bubble) begin
      fwd_a_d = pick_src(id_uses_rs1, id_rs1, ex_rw, ex_rd, mem_rw, mem_rd);
      fwd_b_d = pick_src(id_uses_rs2, id_rs2, ex_rw, ex_rd, mem_rw, mem_rd);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd     <= '0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      mem_rd    <= '0;
      mem_rw    <= 1'b0;
      forward_a <= 2'b00;
      forward_b <= 2'b00;
    end else begin
      mem_rd    <= ex_rd;
      mem_rw    <= ex_rw;
      forward_a <= fwd_a_d;
      forward_b <= fwd_b_d;
      if (bubble) begin
        ex_rd <= '0;
        ex_rw <= 1'b0;
        ex_mr <= 1'b0;
      end else begin
        ex_rd <= id_rd;
        ex_rw <= id_reg_write;
        ex_mr <= id_mem_read;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if ((fwd_a_d != 2'b00 || fwd_b_d != 2'b00) && fwd_count != '1)
        fwd_count <= fwd_count + CNT_W'(1);
    end
  end
`else
  localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed and random checks of forwarding/stall against a
// pipeline-history model. Stats counters are checked when HAZARD_STATS_EN is defined.
module tb_hazard_forward_unit;

  localparam int RW       = 5;
  localparam int TB_CNT_W = 4;

  typedef struct {
    bit             wr;
    bit             ld;
    logic [RW-1:0]  rd;
  } slot_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic [RW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic          stall;
  logic [1:0]    forward_a;
  logic [1:0]    forward_b;
`ifdef HAZARD_STATS_EN
  logic [TB_CNT_W-1:0] stall_count;
  logic [TB_CNT_W-1:0] fwd_count;
  int                  exp_sc;
  int                  exp_fc;
`endif

  slot_t hist[$];
  int    checks = 0;
  int    fails  = 0;
  bit    stalled;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(RW), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .forward_a    (forward_a),
    .forward_b    (forward_b)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
`endif
  );

  // History of what entered EX: hist[1] is now in EX, hist[0] is now in MEM.
  task automatic resetModel();
    slot_t b;
    b.wr = 0; b.ld = 0; b.rd = '0;
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
`ifdef HAZARD_STATS_EN
    exp_sc = 0;
    exp_fc = 0;
`endif
  endtask

  function automatic logic [1:0] modelFwd(bit uses, logic [RW-1:0] rs);
    if (!uses || rs == 0) return 2'b00;
    if (hist[1].wr && hist[1].rd == rs) return 2'b10;
    if (hist[0].wr && hist[0].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(string tag, bit v, bit fl,
                               logic [RW-1:0] rs1, bit u1, logic [RW-1:0] rs2, bit u2,
                               logic [RW-1:0] rd, bit rw, bit mr, output bit stl);
    bit         exp_stall;
    bit         bub;
    logic [1:0] ea;
    logic [1:0] eb;
    slot_t      s;
    @(negedge clk);
    id_valid = v; flush = fl;
    id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    #1;
    exp_stall = v && !fl && hist[1].ld && hist[1].wr && hist[1].rd != 0 &&
                ((u1 && rs1 == hist[1].rd) || (u2 && rs2 == hist[1].rd));
    checkOutput({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    bub = fl || exp_stall || !v;
    ea  = bub ? 2'b00 : modelFwd(u1, rs1);
    eb  = bub ? 2'b00 : modelFwd(u2, rs2);
`ifdef HAZARD_STATS_EN
    if (exp_stall && exp_sc < (1 << TB_CNT_W) - 1) exp_sc++;
    if ((ea != 0 || eb != 0) && exp_fc < (1 << TB_CNT_W) - 1) exp_fc++;
`endif
    s.wr = !bub && rw;
    s.ld = !bub && mr;
    s.rd = rd;
    hist.push_back(s);
    void'(hist.pop_front());
    @(posedge clk);
    #1;
    checkOutput({tag, ".fa"}, 32'(forward_a), 32'(ea));
    checkOutput({tag, ".fb"}, 32'(forward_b), 32'(eb));
`ifdef HAZARD_STATS_EN
    checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'(exp_sc));
    checkOutput({tag, ".fwd_count"}, 32'(fwd_count), 32'(exp_fc));
`endif
    stl = exp_stall;
  endtask

  task automatic alu(string tag, logic [RW-1:0] rd, logic [RW-1:0] rs1, logic [RW-1:0] rs2,
                     bit fl = 0);
    applyStimulus(tag, 1, fl, rs1, 1, rs2, 1, rd, 1, 0, stalled);
  endtask

  task automatic load(string tag, logic [RW-1:0] rd, logic [RW-1:0] rs1);
    applyStimulus(tag, 1, 0, rs1, 1, 5'd0, 0, rd, 1, 1, stalled);
  endtask

  task automatic nop(string tag);
    applyStimulus(tag, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, stalled);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, ".fa"}, 32'(forward_a), 32'd0);
    checkOutput({tag, ".fb"}, 32'(forward_b), 32'd0);
    checkOutput({tag, ".stall"}, 32'(stall), 32'd0);
`ifdef HAZARD_STATS_EN
    checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'd0);
    checkOutput({tag, ".fwd_count"}, 32'(fwd_count), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit            v, fl, u1, u2, rw, mr;
    logic [RW-1:0] rs1, rs2, rd;

    reset_n = 1'b0; id_valid = 0; flush = 0;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = '0; id_reg_write = 0; id_mem_read = 0;
    resetModel();
    #1;
    checkResetOutputs("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back ALU dependency: EX/MEM forward on A only.
    alu("t2.add", 5, 1, 2);
    alu("t2.sub", 6, 5, 7);
    checkOutput("t2.fa_const", 32'(forward_a), 32'h2);
    checkOutput("t2.fb_const", 32'(forward_b), 32'h0);

    // One-instruction gap: MEM/WB forward on both operands.
    alu("t3.add", 5, 1, 2);
    nop("t3.nop");
    alu("t3.or", 8, 5, 5);
    checkOutput("t3.fa_const", 32'(forward_a), 32'h1);
    checkOutput("t3.fb_const", 32'(forward_b), 32'h1);

    // Load-use: one stall cycle, then MEM/WB forward.
    load("t4.lw", 5, 9);
    alu("t4.add_stall", 6, 5, 1);
    checkOutput("t4.stall_seen", 32'(stalled), 32'h1);
    checkOutput("t4.bubble_fa", 32'(forward_a), 32'h0);
    alu("t4.add_held", 6, 5, 1);
    checkOutput("t4.no_stall", 32'(stalled), 32'h0);
    checkOutput("t4.fa_const", 32'(forward_a), 32'h1);

    // x0 never forwards or stalls; youngest of two writers wins.
    alu("t5.wr_x0", 0, 1, 2);
    alu("t5.rd_x0", 1, 0, 0);
    checkOutput("t5.x0_fa", 32'(forward_a), 32'h0);
    load("t5.lw_x0", 0, 3);
    alu("t5.use_x0", 2, 0, 4);
    checkOutput("t5.x0_nostall", 32'(stalled), 32'h0);
    alu("t5.w1", 5, 1, 2);
    alu("t5.w2", 5, 1, 2);
    alu("t5.rd", 7, 5, 3);
    checkOutput("t5.prio_fa", 32'(forward_a), 32'h2);

    // Flush beats a pending load-use stall; the load then forwards from MEM.
    load("t6.lw", 5, 9);
    alu("t6.flushed", 6, 5, 1, 1);
    checkOutput("t6.flush_nostall", 32'(stalled), 32'h0);
    checkOutput("t6.flush_fa", 32'(forward_a), 32'h0);
    alu("t6.next", 7, 5, 2);
    checkOutput("t6.next_fa", 32'(forward_a), 32'h1);

    // Mid-stream reset clears outputs at once and forgets the x5 producer.
    alu("t1.add", 5, 1, 2);
    alu("t1.use", 6, 5, 5);
    @(negedge clk);
    reset_n = 1'b0; id_valid = 0;
    #1;
    resetModel();
    checkResetOutputs("t1.reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    alu("t1.after", 7, 5, 6);
    checkOutput("t1.after_fa", 32'(forward_a), 32'h0);
    checkOutput("t1.after_fb", 32'(forward_b), 32'h0);

    // Random stream over a small register window to provoke hazards.
    stalled = 0;
    v = 0; fl = 0; u1 = 0; u2 = 0; rw = 0; mr = 0; rs1 = '0; rs2 = '0; rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        v   = $urandom_range(0, 9) != 0;
        u1  = $urandom_range(0, 3) != 0;
        u2  = $urandom_range(0, 1) != 0;
        rs1 = RW'($urandom_range(0, 3));
        rs2 = RW'($urandom_range(0, 3));
        rd  = RW'($urandom_range(0, 3));
        rw  = $urandom_range(0, 3) != 0;
        mr  = rw && ($urandom_range(0, 2) == 0);
      end
      fl = $urandom_range(0, 9) == 0;
      applyStimulus("rand", v, fl, rs1, u1, rs2, u2, rd, rw, mr, stalled);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
